// File: rtl/onecount_deserializer_pkg.sv
// Shared definitions for the ones-counter serial front end.
package onecount_deserializer_pkg;

  // Word width shared with the downstream onecount stage.
  localparam int ONECOUNT_WIDTH = 16;

  // Default number of words per frame.
  localparam int FRAME_WORDS_DEFAULT = 4;

  // Deserializer FSM states.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/onecount_hold_reg.sv
// Single-entry valid/ready holding register between word assembly and the
// onecount stage. A push into a full, stalled register drops the new word
// and raises the sticky overrun flag.
module onecount_hold_reg
  import onecount_deserializer_pkg::*;
#(
  parameter int WIDTH = ONECOUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_word,
  input  logic             ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic blocked;

  assign blocked = valid && !ready;

  // Load on push unless the held word is stalled; a simultaneous pop lets the push through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (push) begin
      if (!blocked) begin
        data  <= push_word;
        valid <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  // Sticky overrun: setting a dropped word takes priority over clearing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (push && blocked) begin
      overrun <= 1'b1;
    end else if (clr_err) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/onecount_deserializer.sv
// Serial-to-parallel front end: assembles MSB-first framed bits into words
// and hands them to the onecount stage through a holding register.
module onecount_deserializer
  import onecount_deserializer_pkg::*;
#(
  parameter int WIDTH       = ONECOUNT_WIDTH,
  parameter int FRAME_WORDS = FRAME_WORDS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic             bit_valid,
  input  logic             serial_in,
  output logic [WIDTH-1:0] DATA,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_done,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int BC_W = $clog2(WIDTH);
  localparam int WC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WIDTH - 1);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(FRAME_WORDS - 1);

  state_t            state;
  logic [BC_W-1:0]   bit_cnt;
  logic [WC_W-1:0]   word_cnt;
  // Only the first WIDTH-1 bits need storing: the last bit goes straight
  // into the holding register together with them.
  logic [WIDTH-2:0]  shreg;
  logic [WIDTH-1:0]  shifted;
  logic              restart;
  logic              word_end;

  assign shifted  = {shreg, serial_in};
  assign restart  = bit_valid && sof;
  assign word_end = (state == ST_COLLECT) && bit_valid && !sof && (bit_cnt == BIT_LAST);

  // Frame FSM: sof (re)starts a frame, WIDTH bits make a word, FRAME_WORDS words end it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      shreg      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (restart) begin
        shreg    <= shifted[WIDTH-2:0];
        bit_cnt  <= BC_W'(1);
        word_cnt <= '0;
        state    <= ST_COLLECT;
      end else if ((state == ST_COLLECT) && bit_valid) begin
        shreg <= shifted[WIDTH-2:0];
        if (bit_cnt == BIT_LAST) begin
          bit_cnt <= '0;
          if (word_cnt == WORD_LAST) begin
            word_cnt   <= '0;
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            word_cnt <= word_cnt + WC_W'(1);
          end
        end else begin
          bit_cnt <= bit_cnt + BC_W'(1);
        end
      end
    end
  end

  // Sticky frame error on sof arriving mid-frame; a new error beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (restart && (state == ST_COLLECT)) begin
      frame_err <= 1'b1;
    end else if (clr_err) begin
      frame_err <= 1'b0;
    end
  end

  onecount_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (word_end),
    .push_word(shifted),
    .ready    (data_ready),
    .clr_err  (clr_err),
    .data     (DATA),
    .valid    (data_valid),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_onecount_deserializer.sv
// Self-checking bench for onecount_deserializer: directed scenarios followed
// by randomized traffic, all compared every cycle against a word/frame model.
module tb_onecount_deserializer;

  logic        clk;
  logic        rst_n;
  logic        sof;
  logic        bit_valid;
  logic        serial_in;
  logic [15:0] DATA;
  logic        data_valid;
  logic        data_ready;
  logic        frame_done;
  logic        overrun;
  logic        frame_err;
  logic        clr_err;

  int tests_run;
  int tests_failed;

  // Reference model state: expected outputs plus frame progress in plain counts.
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_done;
  logic        m_ovr;
  logic        m_ferr;
  bit          in_frame;
  int          nbits;
  int          nwords;
  int          acc;

  onecount_deserializer #(
    .WIDTH      (16),
    .FRAME_WORDS(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sof       (sof),
    .bit_valid (bit_valid),
    .serial_in (serial_in),
    .DATA      (DATA),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_done(frame_done),
    .overrun   (overrun),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Predict the outputs after the coming edge from the values sampled there.
  function automatic void modelStep(input logic s, input logic bv, input logic si,
                                    input logic rdy, input logic clr, input logic rstn);
    bit          push;
    logic [15:0] word;
    bit          ovr_set;
    bit          ferr_set;
    push     = 0;
    word     = '0;
    ovr_set  = 0;
    ferr_set = 0;
    if (!rstn) begin
      m_data = '0; m_valid = 0; m_done = 0; m_ovr = 0; m_ferr = 0;
      in_frame = 0; nbits = 0; nwords = 0; acc = 0;
      return;
    end
    m_done = 0;
    if (bv && s) begin
      if (in_frame) ferr_set = 1;
      in_frame = 1;
      acc      = int'(si);
      nbits    = 1;
      nwords   = 0;
    end else if (bv && in_frame) begin
      acc   = ((acc * 2) + int'(si)) % 65536;
      nbits = nbits + 1;
      if (nbits == 16) begin
        push   = 1;
        word   = acc[15:0];
        nbits  = 0;
        nwords = nwords + 1;
        if (nwords == 4) begin
          m_done   = 1;
          in_frame = 0;
          nwords   = 0;
        end
      end
    end
    if (push) begin
      if (m_valid && !rdy) ovr_set = 1;
      else begin
        m_data  = word;
        m_valid = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (ovr_set) m_ovr = 1;
    else if (clr) m_ovr = 0;
    if (ferr_set) m_ferr = 1;
    else if (clr) m_ferr = 0;
  endfunction

  // Drive one cycle of inputs, advance the model, then compare at the falling edge.
  task automatic applyStimulus(input logic s, input logic bv, input logic si,
                               input logic rdy, input logic clr, input logic rstn);
    sof        = s;
    bit_valid  = bv;
    serial_in  = si;
    data_ready = rdy;
    clr_err    = clr;
    rst_n      = rstn;
    modelStep(s, bv, si, rdy, clr, rstn);
    @(negedge clk);
    checkOutput("DATA", 32'(DATA), 32'(m_data));
    checkOutput("data_valid", 32'(data_valid), 32'(m_valid));
    checkOutput("frame_done", 32'(frame_done), 32'(m_done));
    checkOutput("overrun", 32'(overrun), 32'(m_ovr));
    checkOutput("frame_err", 32'(frame_err), 32'(m_ferr));
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendWord(input logic [15:0] w, input logic first_sof,
                          input logic rdy_body, input logic rdy_last);
    for (int i = 15; i >= 0; i--) begin
      applyStimulus((i == 15) && first_sof, 1'b1, w[i], (i == 0) ? rdy_last : rdy_body, 1'b0, 1'b1);
    end
  endtask

  logic [15:0] frame_words [4];
  int          frame_counts [4];
  logic [15:0] tmp;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    frame_words  = '{16'hffff, 16'h0000, 16'h5555, 16'h0007};
    frame_counts = '{16, 0, 8, 3};

    // Reset values.
    doReset();
    checkOutput("rst_DATA", 32'(DATA), 32'h0);
    checkOutput("rst_valid", 32'(data_valid), 32'h0);

    // Single word 16'hc00f.
    sendWord(16'hc00f, 1'b1, 1'b1, 1'b1);
    checkOutput("c00f_data", 32'(DATA), 32'hc00f);
    checkOutput("c00f_valid", 32'(data_valid), 32'h1);
    checkOutput("c00f_count", 32'($countones(DATA)), 32'd6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("c00f_pop", 32'(data_valid), 32'h0);

    // Full four-word frame, streamed back to back.
    doReset();
    for (int w = 0; w < 4; w++) begin
      sendWord(frame_words[w], w == 0, 1'b1, 1'b1);
      checkOutput("frm_valid", 32'(data_valid), 32'h1);
      checkOutput("frm_count", 32'($countones(DATA)), 32'(frame_counts[w]));
      checkOutput("frm_done", 32'(frame_done), (w == 3) ? 32'h1 : 32'h0);
    end
    // Back-to-back next frame right after the last bit.
    sendWord(16'h8001, 1'b1, 1'b1, 1'b1);
    checkOutput("b2b_ferr", 32'(frame_err), 32'h0);
    checkOutput("b2b_data", 32'(DATA), 32'h8001);

    // Overrun with the holding register stalled, then clear.
    doReset();
    sendWord(16'hffe0, 1'b1, 1'b0, 1'b0);
    sendWord(16'h1234, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr_data", 32'(DATA), 32'hffe0);
    checkOutput("ovr_flag", 32'(overrun), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("ovr_clr", 32'(overrun), 32'h0);
    // Pop coinciding with push: new word taken, no overrun.
    sendWord(16'h0f0f, 1'b0, 1'b0, 1'b1);
    checkOutput("pp_data", 32'(DATA), 32'h0f0f);
    checkOutput("pp_valid", 32'(data_valid), 32'h1);
    checkOutput("pp_ovr", 32'(overrun), 32'h0);

    // sof mid-frame after 7 bits of word 2.
    doReset();
    sendWord(16'h1111, 1'b1, 1'b1, 1'b1);
    tmp = 16'hbeef;
    for (int i = 15; i >= 9; i--) applyStimulus(1'b0, 1'b1, tmp[i], 1'b1, 1'b0, 1'b1);
    sendWord(16'haaaa, 1'b1, 1'b1, 1'b1);
    checkOutput("ferr_flag", 32'(frame_err), 32'h1);
    checkOutput("ferr_data", 32'(DATA), 32'haaaa);
    checkOutput("ferr_done0", 32'(frame_done), 32'h0);
    for (int w = 0; w < 3; w++) begin
      sendWord(16'(w * 16'h0101), 1'b0, 1'b1, 1'b1);
      checkOutput("ferr_done", 32'(frame_done), (w == 2) ? 32'h1 : 32'h0);
    end

    // Reset mid-word, then bits without sof.
    for (int i = 0; i < 5; i++) applyStimulus(i == 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    checkOutput("rmw_valid", 32'(data_valid), 32'h0);
    checkOutput("rmw_data", 32'(DATA), 32'h0);
    checkOutput("rmw_ferr", 32'(frame_err), 32'h0);
    checkOutput("rmw_ovr", 32'(overrun), 32'h0);

    // Randomized traffic against the model.
    doReset();
    for (int c = 0; c < 4000; c++) begin
      applyStimulus(1'($urandom_range(0, 39) == 0),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 29) == 0),
                    1'($urandom_range(0, 299) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
